// File: rtl/vpu_frame_capture.sv
// rtl/vpu_frame_capture.sv - VPU pixel-stream sink that writes one frame into a framebuffer port
// Define VPU_CAP_CRC_EN to build the per-frame CRC-32 over written pixels; otherwise frame_crc is 0.
module vpu_frame_capture #(
    parameter int   H_ACTIVE    = 320,
    parameter int   V_ACTIVE    = 240,
    parameter int   H_START     = 16,
    parameter int   V_START     = 8,
    parameter logic SYNC_ACTIVE = 1'b0,
    parameter int   FB_ADDR_W   = 17
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 dot_clk,
    input  logic [31:0]          color,
    input  logic                 hsync,
    input  logic                 vsync,
    input  logic                 cap_start,
    input  logic                 cap_cont,
    input  logic                 cap_stop,
    output logic                 fb_en,
    output logic                 fb_we,
    output logic [FB_ADDR_W-1:0] fb_addr,
    output logic [31:0]          fb_din,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [15:0]          h_total,
    output logic [15:0]          v_total,
    output logic [31:0]          frame_crc
);
    localparam logic [15:0]          H_LO      = 16'(H_START);
    localparam logic [15:0]          H_HI      = 16'(H_START + H_ACTIVE);
    localparam logic [15:0]          V_LO      = 16'(V_START);
    localparam logic [15:0]          V_HI      = 16'(V_START + V_ACTIVE);
    localparam logic [23:0]          PIX_TOTAL = 24'(H_ACTIVE * V_ACTIVE);
    localparam logic [FB_ADDR_W-1:0] LINE_W    = FB_ADDR_W'(H_ACTIVE);

    typedef enum logic [1:0] {S_IDLE, S_WAIT_VSYNC, S_CAPTURE} state_t;
    state_t state, state_nx;

    logic                 dot_q, stb;
    logic                 s_vld, s_hs, s_vs, hs_prev, vs_prev;
    logic [31:0]          s_color;
    logic [15:0]          h_cnt, v_cnt, h_meas, v_meas;
    logic [23:0]          pix_cnt, pix_cnt_upd;
    logic                 hs_lead, vs_lead, active, pix_hit, wr;
    logic                 frame_end, start_arm;
    logic [FB_ADDR_W-1:0] pix_addr;

    // Sampled strobe data is staged one cycle so all position logic works off registered syncs.
    assign stb         = dot_clk & ~dot_q;
    assign hs_lead     = s_vld & s_hs & ~hs_prev;
    assign vs_lead     = s_vld & s_vs & ~vs_prev;
    assign active      = s_vld & ~s_hs & (h_cnt >= H_LO) & (h_cnt < H_HI)
                         & (v_cnt >= V_LO) & (v_cnt < V_HI);
    assign pix_hit     = (state == S_CAPTURE) & active & ~cap_stop;
    assign wr          = pix_hit & (pix_cnt < PIX_TOTAL);
    assign pix_cnt_upd = pix_cnt + {23'b0, pix_hit};
    assign pix_addr    = FB_ADDR_W'(v_cnt - V_LO) * LINE_W + FB_ADDR_W'(h_cnt - H_LO);
    assign busy        = (state != S_IDLE);
    assign fb_we       = fb_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        frame_end = 1'b0;
        start_arm = 1'b0;
        case (state)
            S_IDLE: if (cap_start) begin
                state_nx  = S_WAIT_VSYNC;
                start_arm = 1'b1;
            end
            S_WAIT_VSYNC: if (vs_lead) state_nx = S_CAPTURE;
            S_CAPTURE: if (vs_lead) begin
                frame_end = 1'b1;
                state_nx  = cap_cont ? S_CAPTURE : S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
        if (cap_stop) begin
            state_nx  = S_IDLE;
            frame_end = 1'b0;
            start_arm = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dot_q   <= 1'b0;
            s_vld   <= 1'b0;
            s_hs    <= 1'b0;
            s_vs    <= 1'b0;
            s_color <= '0;
            hs_prev <= 1'b0;
            vs_prev <= 1'b0;
            h_cnt   <= '0;
            v_cnt   <= '0;
            h_meas  <= '0;
            v_meas  <= '0;
            h_total <= '0;
            v_total <= '0;
            pix_cnt <= '0;
            fb_en   <= 1'b0;
            fb_addr <= '0;
            fb_din  <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            dot_q <= dot_clk;
            s_vld <= stb;
            if (stb) begin
                s_color <= color;
                s_hs    <= (hsync == SYNC_ACTIVE);
                s_vs    <= (vsync == SYNC_ACTIVE);
            end
            if (s_vld) begin
                hs_prev <= s_hs;
                vs_prev <= s_vs;
                h_cnt   <= s_hs ? 16'd0 : h_cnt + 16'd1;
                if (s_vs)         v_cnt <= '0;
                else if (hs_lead) v_cnt <= v_cnt + 16'd1;
                // Totals count half-open intervals starting at each leading edge.
                h_meas <= hs_lead ? 16'd1 : h_meas + 16'd1;
                if (hs_lead) h_total <= h_meas;
                if (vs_lead) begin
                    v_total <= v_meas;
                    v_meas  <= {15'b0, hs_lead};
                end else begin
                    v_meas  <= v_meas + {15'b0, hs_lead};
                end
            end
            fb_en <= wr;
            if (wr) begin
                fb_addr <= pix_addr;
                fb_din  <= s_color;
            end
            done <= frame_end;
            if (start_arm) begin
                err     <= 1'b0;
                pix_cnt <= '0;
            end else if (frame_end) begin
                if (pix_cnt_upd != PIX_TOTAL) err <= 1'b1;
                pix_cnt <= '0;
            end else begin
                pix_cnt <= pix_cnt_upd;
            end
        end
    end

`ifdef VPU_CAP_CRC_EN
    // Reflected CRC-32, one 32-bit word per call, least significant byte first.
    function automatic logic [31:0] crc32_word(input logic [31:0] c, input logic [31:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 32; i++)
            r = (r >> 1) ^ ((r[0] ^ d[i]) ? 32'hEDB88320 : 32'h0);
        return r;
    endfunction

    logic [31:0] crc_acc, crc_upd;
    assign crc_upd = wr ? crc32_word(crc_acc, s_color) : crc_acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_acc   <= '1;
            frame_crc <= '0;
        end else if (start_arm) begin
            crc_acc   <= '1;
        end else if (frame_end) begin
            frame_crc <= ~crc_upd;
            crc_acc   <= '1;
        end else begin
            crc_acc   <= crc_upd;
        end
    end
`else
    assign frame_crc = 32'h0;
`endif

endmodule

// File: tb/tb_vpu_frame_capture.sv
// tb/tb_vpu_frame_capture.sv - randomized self-checking bench for vpu_frame_capture against a frame-level model
module tb_vpu_frame_capture;
    localparam int HA = 4, VA = 3, HS = 1, VS = 1, AW = 17, DOTS = 8, LINES = 6;

    logic          clk = 1'b0, rst = 1'b1;
    logic          dot_clk = 1'b0, hsync = 1'b1, vsync = 1'b1;
    logic          cap_start = 1'b0, cap_cont = 1'b0, cap_stop = 1'b0;
    logic [31:0]   color = '0;
    logic          fb_en, fb_we, busy, done, err;
    logic [AW-1:0] fb_addr;
    logic [31:0]   fb_din, frame_crc;
    logic [15:0]   h_total, v_total;

    vpu_frame_capture #(
        .H_ACTIVE(HA), .V_ACTIVE(VA), .H_START(HS), .V_START(VS),
        .SYNC_ACTIVE(1'b0), .FB_ADDR_W(AW)
    ) dut (
        .clk(clk), .rst(rst), .dot_clk(dot_clk), .color(color),
        .hsync(hsync), .vsync(vsync), .cap_start(cap_start), .cap_cont(cap_cont),
        .cap_stop(cap_stop), .fb_en(fb_en), .fb_we(fb_we), .fb_addr(fb_addr),
        .fb_din(fb_din), .busy(busy), .done(done), .err(err),
        .h_total(h_total), .v_total(v_total), .frame_crc(frame_crc)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0, n_pass = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    int unsigned exp_addr[$], exp_data[$], exp_cyc[$];
    int unsigned obs_addr[$], obs_data[$], obs_cyc[$];
    int unsigned exp_done_cyc[$], exp_done_crc[$];
    bit          exp_done_err[$], exp_done_busy[$];
    int unsigned obs_done_cyc[$];
    bit          want_busy = 1'b0;
    int          busy_drops = 0;

    // Frame-level model state: running CRC and pixel count of the frame being captured.
    logic [31:0] m_crc;
    int          m_pix;
    bit          pend = 1'b0, pend_err;
    logic [31:0] pend_crc;

    function automatic logic [31:0] crc_add(input logic [31:0] c, input logic [31:0] w);
        logic [31:0] r;
        r = c;
        for (int b = 0; b < 4; b++) begin
            r = r ^ {24'h0, w[8*b +: 8]};
            for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (fb_en) begin
            obs_addr.push_back(32'(fb_addr));
            obs_data.push_back(fb_din);
            obs_cyc.push_back(cyc);
            check("fb_we", 32'(fb_we), 1);
        end
        if (done) begin
            obs_done_cyc.push_back(cyc);
            if (exp_done_cyc.size() == 0) check("done_unexpected", 1, 0);
            else begin
                check("done_cyc", cyc, exp_done_cyc.pop_front());
                check("done_err", 32'(err), 32'(exp_done_err.pop_front()));
                check("done_busy", 32'(busy), 32'(exp_done_busy.pop_front()));
                check("frame_crc", frame_crc, exp_done_crc.pop_front());
            end
        end
        if (want_busy && !busy) busy_drops++;
    end

    // One frame of nlines x DOTS dots; line 0 carries vsync, dot 0 of every line carries hsync.
    // mode: 0 = 0x00YY00XX active pattern, 1 = random, 2 = zero active pixels.
    task automatic send_frame(input int nlines, input int mode, input bit cap,
                              input int stop_at, input int rst_line, input int stretch_line);
        bit          capturing, stopped, act, rst_here;
        logic [31:0] col;
        logic [7:0]  x8, y8;
        capturing = cap;
        stopped   = 1'b0;
        if (cap) begin
            m_crc = '1;
            m_pix = 0;
        end
        for (int l = 0; l < nlines; l++) begin
            for (int d = 0; d < DOTS; d++) begin
                @(posedge clk); #1;
                if (l == 0 && d == 0 && pend) begin
                    exp_done_cyc.push_back(cyc + 2);
                    exp_done_err.push_back(pend_err);
                    exp_done_busy.push_back(cap_cont);
`ifdef VPU_CAP_CRC_EN
                    exp_done_crc.push_back(pend_crc);
`else
                    exp_done_crc.push_back(0);
`endif
                    pend = 1'b0;
                end
                if (stop_at >= 0 && capturing && m_pix == stop_at) begin
                    cap_stop  = 1'b1;
                    capturing = 1'b0;
                    stopped   = 1'b1;
                end
                act      = (l >= 1 && l <= VA && d >= 1 + HS && d < 1 + HS + HA);
                rst_here = (l == rst_line && d == 4);
                x8       = 8'(d - 1 - HS);
                y8       = 8'(l - VS);
                case (mode)
                    0:       col = act ? {8'h00, y8, 8'h00, x8} : $urandom;
                    2:       col = act ? 32'h0 : $urandom;
                    default: col = $urandom;
                endcase
                dot_clk = 1'b1;
                color   = col;
                hsync   = (d == 0) ? 1'b0 : 1'b1;
                vsync   = (l == 0) ? 1'b0 : 1'b1;
                if (capturing && act && !rst_here) begin
                    exp_addr.push_back((l - VS) * HA + (d - 1 - HS));
                    exp_data.push_back(col);
                    exp_cyc.push_back(cyc + 2);
                    m_crc = crc_add(m_crc, col);
                    m_pix++;
                end
                if (l == stretch_line && d == 3) begin
                    @(posedge clk); #1;
                    @(posedge clk); #1;
                end
                @(posedge clk); #1;
                dot_clk  = 1'b0;
                cap_stop = 1'b0;
                if (stopped) begin
                    @(negedge clk);
                    check("abort_busy", 32'(busy), 0);
                    stopped = 1'b0;
                end
                if (rst_here) begin
                    @(negedge clk); #2;
                    rst = 1'b1;
                    #1;
                    check("arst_ctl", {27'b0, fb_en, fb_we, busy, done, err}, 0);
                    check("arst_addr", 32'(fb_addr), 0);
                    check("arst_din", fb_din, 0);
                    check("arst_totals", {h_total, v_total}, 0);
                    check("arst_crc", frame_crc, 0);
                    @(posedge clk); #1;
                    rst = 1'b0;
                    return;
                end
            end
        end
        if (capturing) begin
            pend     = 1'b1;
            pend_err = (m_pix != HA * VA);
            pend_crc = ~m_crc;
        end
    endtask

    task automatic arm();
        @(posedge clk); #1;
        cap_start = 1'b1;
        @(negedge clk);
        check("arm_busy_before", 32'(busy), 0);
        @(posedge clk); #1;
        cap_start = 1'b0;
        @(negedge clk);
        check("arm_busy_after", 32'(busy), 1);
        check("arm_err_clear", 32'(err), 0);
    endtask

    task automatic compare_writes(input string tag);
        check({tag, "_nwrites"}, obs_addr.size(), exp_addr.size());
        for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
            check({tag, "_addr"}, obs_addr[i], exp_addr[i]);
            check({tag, "_data"}, obs_data[i], exp_data[i]);
            check({tag, "_cyc"}, obs_cyc[i], exp_cyc[i]);
        end
        check({tag, "_done_missing"}, exp_done_cyc.size(), 0);
        exp_addr.delete(); exp_data.delete(); exp_cyc.delete();
        obs_addr.delete(); obs_data.delete(); obs_cyc.delete();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ctl", {27'b0, fb_en, fb_we, busy, done, err}, 0);
        check("rst_addr_din", 32'(fb_addr) | fb_din, 0);
        check("rst_totals", {h_total, v_total}, 0);
        check("rst_crc", frame_crc, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        send_frame(LINES, 1, 0, -1, -1, -1);

        // Single frame with coordinate pattern
        arm();
        send_frame(LINES, 0, 1, -1, -1, -1);
        send_frame(LINES, 1, 0, -1, -1, -1);
        compare_writes("single");
        check("h_total", 32'(h_total), DOTS);
        check("v_total", 32'(v_total), LINES);
        check("single_idle", 32'(busy), 0);

        // Continuous mode over three frames
        cap_cont = 1'b1;
        arm();
        obs_done_cyc.delete();
        busy_drops = 0;
        want_busy  = 1'b1;
        send_frame(LINES, 1, 1, -1, -1, -1);
        send_frame(LINES, 1, 1, -1, -1, -1);
        send_frame(LINES, 1, 1, -1, -1, -1);
        want_busy = 1'b0;
        cap_cont  = 1'b0;
        send_frame(LINES, 1, 0, -1, -1, -1);
        compare_writes("cont");
        check("cont_busy_held", busy_drops, 0);
        check("cont_ndone", obs_done_cyc.size(), 3);
        if (obs_done_cyc.size() >= 3) begin
            check("cont_gap1", obs_done_cyc[1] - obs_done_cyc[0], 2 * DOTS * LINES);
            check("cont_gap2", obs_done_cyc[2] - obs_done_cyc[1], 2 * DOTS * LINES);
        end
        check("cont_idle", 32'(busy), 0);

        // Short frame: two active lines
        arm();
        send_frame(3, 1, 1, -1, -1, -1);
        send_frame(LINES, 1, 0, -1, -1, -1);
        compare_writes("short");
        check("short_err", 32'(err), 1);
        check("short_idle", 32'(busy), 0);
        check("short_v_total", 32'(v_total), 3);

        // Abort after five pixels, then a clean capture
        arm();
        send_frame(LINES, 1, 1, 5, -1, -1);
        send_frame(LINES, 1, 0, -1, -1, -1);
        compare_writes("abort");
        arm();
        send_frame(LINES, 0, 1, -1, -1, -1);
        send_frame(LINES, 1, 0, -1, -1, -1);
        compare_writes("recap");
        check("recap_err", 32'(err), 0);

        // Asynchronous reset mid-line, then a capture with one dot held high for three cycles
        arm();
        send_frame(LINES, 1, 1, -1, 2, -1);
        compare_writes("arst");
        check("arst_idle", 32'(busy), 0);
        arm();
        send_frame(LINES, 1, 1, -1, -1, 2);
        send_frame(LINES, 1, 0, -1, -1, -1);
        compare_writes("stretch");
        check("stretch_h_total", 32'(h_total), DOTS);

        // All-zero frame for the CRC path
        arm();
        send_frame(LINES, 2, 1, -1, -1, -1);
        send_frame(LINES, 1, 0, -1, -1, -1);
        compare_writes("zero");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end
endmodule
